cam_bin_downsampler: RTL
========================

Name: cam_bin_downsampler

Overview:
Parametrised successor to the camera capture front end. Captures one RGB565 frame from the OV7670-style byte stream on request. Converts each pixel to 8-bit luma, crops a window and box-averages it into an OUT_W x OUT_H grid of power-of-two bins. Writes one averaged word per bin into the classifier input BRAM and signals completion.

Parameters:
IN_W, 640, active pixels per line
IN_H, 480, active lines per frame
OUT_W, 28, output grid columns
OUT_H, 28, output grid rows
BIN_LOG2, 4, bin edge = 2^BIN_LOG2 pixels (square bins)
CROP_X0, 96, first cropped column; window width = OUT_W<<BIN_LOG2
CROP_Y0, 16, first cropped line; window height = OUT_H<<BIN_LOG2
ADDR_W, 10, BRAM address width
DOUT_W, 16, BRAM data width; luma is zero-extended

Ports:
pclk  in  1  camera pixel clock, sole clock
rst_n  in  1  asynchronous active-low reset
data  in  8  camera byte bus, synchronous to pclk
vsync  in  1  high during vertical blanking
hsync  in  1  high while line bytes are valid (href)
take_photo  in  1  capture request level
bram_addr_cam  out  ADDR_W  write address = row*OUT_W + col
bram_din_cam  out  DOUT_W  averaged luma
bram_en_cam  out  1  BRAM enable
bram_we_cam  out  1  BRAM write strobe
ready  out  1  high in IDLE
frame_done  out  1  1-cycle pulse after last bin write
frame_err  out  1  1-cycle pulse on aborted frame
overrun  out  1  sticky: flush collided with next line

Behaviour:
- Reset (any cycle, including mid-frame): state IDLE; all outputs 0 except ready=1; accumulators, counters and overrun cleared.
- States: IDLE -> ARMED when take_photo=1. ARMED -> CAPTURE on vsync falling edge. CAPTURE <-> FLUSH. FLUSH -> DONE after last band. DONE -> IDLE after one cycle, with the frame_done pulse.
- Byte pairing: the phase toggles on each hsync=1 cycle; first byte = pixel[15:8], second = pixel[7:0]. Phase clears whenever hsync=0, so a dangling odd byte is discarded.
- Luma: r8={R5,R5[4:2]}, g8={G6,G6[5:4]}, b8={B5,B5[4:2]}; Y=(r8+2*g8+b8)>>2, registered 1 cycle after the second byte.
- Counters: x counts pixels per line and clears on hsync fall. y increments on each hsync fall with x>0, and clears on vsync.
- Accumulation: pixels with CROP_X0<=x<CROP_X0+(OUT_W<<BIN_LOG2) and y inside the crop window add Y into acc[(x-CROP_X0)>>BIN_LOG2]. acc is an array of OUT_W registers, width 8+2*BIN_LOG2, updated 1 cycle after Y is valid. Out-of-window pixels are ignored.
- Band end: on hsync fall after line CROP_Y0+(b+1)*2^BIN_LOG2-1, enter FLUSH.
- FLUSH writes col 0..OUT_W-1 on consecutive cycles: en=we=1, addr=b*OUT_W+col, din=acc[col]>>(2*BIN_LOG2); the acc entry is cleared on the same cycle. After col OUT_W-1, return to CAPTURE, or go to DONE if b=OUT_H-1.
- Flush/line collision: if hsync rises during FLUSH, set overrun. The flush still completes, but the first pixels of the new line are not accumulated.
- en and we are 0 outside FLUSH.
- take_photo is sampled only in IDLE; deasserting it mid-capture has no effect.
- Early vsync: vsync rising in CAPTURE or FLUSH before band OUT_H-1 is flushed -> frame_err pulse, state IDLE, acc cleared. Already-written words are not restored.
- Arithmetic: no overflow is possible. The maximum sum 255*4^BIN_LOG2 fits the accumulator exactly.

Optional Feature:
CAM_INVERT_EN. Defined: the written value is 255 minus the average, giving MNIST-style white digit on black. Undefined: the average is written unchanged.

Test Plan:
- Reset, take_photo=1, full 640x480 frame of 0xFFFF with 200-pclk blanking: exactly 784 writes, addr 0..783 in order, din=255, one frame_done, overrun=0.
- Frame of 0xF800 (red) -> all din=63. Frame of 0x07E0 (green) -> all din=127.
- Cropped-window pixels 0x0000, outside-window pixels 0xFFFF -> all din=0. Proves cropping and outside-window pixels ignored.
- Pixel at x=96..111, y=16..31 = 0xFFFF, rest 0x0000 -> addr 0 din=255, every other addr din=0.
- take_photo=0 across a frame -> no bram_we_cam, ready stays 1. vsync rises after 100 lines -> frame_err pulse, no frame_done, state IDLE.
- Horizontal blanking of 10 pclk (< OUT_W) -> overrun set and held until rst_n=0. With CAM_INVERT_EN, the all-0xFFFF frame -> all din=0.

Source files
------------

// File: rtl/cam_bin_downsampler_if.sv
// Camera byte bus, classifier BRAM write port and capture control/status for cam_bin_downsampler.
// master = camera/controller side, slave = the downsampler.
interface cam_bin_downsampler_if #(
    parameter int ADDR_W = 10,
    parameter int DOUT_W = 16
);
    logic [7:0]        data;
    logic              vsync;
    logic              hsync;
    logic              take_photo;
    logic [ADDR_W-1:0] bram_addr_cam;
    logic [DOUT_W-1:0] bram_din_cam;
    logic              bram_en_cam;
    logic              bram_we_cam;
    logic              ready;
    logic              frame_done;
    logic              frame_err;
    logic              overrun;

    modport master (
        output data, vsync, hsync, take_photo,
        input  bram_addr_cam, bram_din_cam, bram_en_cam, bram_we_cam,
        input  ready, frame_done, frame_err, overrun
    );

    modport slave (
        input  data, vsync, hsync, take_photo,
        output bram_addr_cam, bram_din_cam, bram_en_cam, bram_we_cam,
        output ready, frame_done, frame_err, overrun
    );
endinterface

// File: rtl/cam_bin_downsampler.sv
// One-shot RGB565 frame capture -> 8-bit luma -> cropped power-of-two box average into a BRAM grid.
// Optional CAM_INVERT_EN: write 255 - average (white digit on black).
module cam_bin_downsampler #(
    parameter int IN_W     = 640,
    parameter int IN_H     = 480,
    parameter int OUT_W    = 28,
    parameter int OUT_H    = 28,
    parameter int BIN_LOG2 = 4,
    parameter int CROP_X0  = 96,
    parameter int CROP_Y0  = 16,
    parameter int ADDR_W   = 10,
    parameter int DOUT_W   = 16
) (
    input  logic pclk,
    input  logic rst_n,
    cam_bin_downsampler_if.slave bus
);
    localparam int BIN   = 1 << BIN_LOG2;
    localparam int ACC_W = 8 + 2 * BIN_LOG2;
    localparam int CW    = $clog2((IN_W > IN_H) ? IN_W : IN_H) + 2;
    localparam int BW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int HW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [CW-1:0] X_LO   = CW'(CROP_X0);
    localparam logic [CW-1:0] X_HI   = CW'(CROP_X0 + (OUT_W << BIN_LOG2));
    localparam logic [CW-1:0] Y_LO   = CW'(CROP_Y0);
    localparam logic [CW-1:0] Y_HI   = CW'(CROP_Y0 + (OUT_H << BIN_LOG2));
    localparam logic [CW-1:0] Y_MASK = CW'(BIN - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CAPTURE, S_FLUSH, S_DONE} state_t;

    state_t              r_state;
    logic                r_hs_d, r_vs_d;
    logic                r_phase;
    logic [7:0]          r_hi;
    logic [CW-1:0]       r_xcnt, r_ycnt;
    logic                r_yv, r_ywin;
    logic [7:0]          r_luma;
    logic [BW-1:0]       r_ybin;
    logic [ACC_W-1:0]    r_acc [OUT_W];
    logic [BW-1:0]       r_col;
    logic [HW-1:0]       r_band;
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DOUT_W-1:0]   r_din;
    logic                r_we, r_done, r_err, r_overrun;

    logic                w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
    logic [7:0]          w_r8, w_g8, w_b8, w_luma;
    logic                w_in_win, w_band_end;
    logic [BW-1:0]       w_bin;
    logic [CW-1:0]       w_rel_y;
    logic [ACC_W-1:0]    w_acc_sel;
    logic [7:0]          w_avg, w_wval;

    assign w_hs_rise = bus.hsync & ~r_hs_d;
    assign w_hs_fall = ~bus.hsync & r_hs_d;
    assign w_vs_rise = bus.vsync & ~r_vs_d;
    assign w_vs_fall = ~bus.vsync & r_vs_d;

    // Current byte is the low half of the pixel whenever r_phase is set.
    assign w_r8   = {r_hi[7:3], r_hi[7:5]};
    assign w_g8   = {r_hi[2:0], bus.data[7:5], r_hi[2:1]};
    assign w_b8   = {bus.data[4:0], bus.data[4:2]};
    assign w_luma = 8'(({2'b00, w_r8} + {1'b0, w_g8, 1'b0} + {2'b00, w_b8}) >> 2);

    assign w_in_win = (r_xcnt >= X_LO) && (r_xcnt < X_HI) &&
                      (r_ycnt >= Y_LO) && (r_ycnt < Y_HI);
    assign w_bin    = BW'((r_xcnt - X_LO) >> BIN_LOG2);

    // The line just finished is the last line of the band currently being filled.
    assign w_rel_y    = r_ycnt - Y_LO;
    assign w_band_end = (r_ycnt >= Y_LO) && (r_ycnt < Y_HI) &&
                        ((w_rel_y & Y_MASK) == Y_MASK) &&
                        ((w_rel_y >> BIN_LOG2) == CW'(r_band));

    assign w_acc_sel = r_acc[r_col];
    assign w_avg     = 8'(w_acc_sel >> (2 * BIN_LOG2));
`ifdef CAM_INVERT_EN
    assign w_wval    = 8'd255 - w_avg;
`else
    assign w_wval    = w_avg;
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_hs_d    <= 1'b0;
            r_vs_d    <= 1'b0;
            r_phase   <= 1'b0;
            r_hi      <= '0;
            r_xcnt    <= '0;
            r_ycnt    <= '0;
            r_yv      <= 1'b0;
            r_ywin    <= 1'b0;
            r_luma    <= '0;
            r_ybin    <= '0;
            for (int i = 0; i < OUT_W; i++) r_acc[i] <= '0;
            r_col     <= '0;
            r_band    <= '0;
            r_waddr   <= '0;
            r_addr    <= '0;
            r_din     <= '0;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_hs_d <= bus.hsync;
            r_vs_d <= bus.vsync;
            r_yv   <= 1'b0;
            r_we   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (!bus.hsync) begin
                r_phase <= 1'b0;
            end else begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_hi <= bus.data;
                end else begin
                    r_yv   <= 1'b1;
                    r_luma <= w_luma;
                    r_ywin <= w_in_win;
                    r_ybin <= w_bin;
                    r_xcnt <= r_xcnt + CW'(1);
                end
            end

            if (bus.vsync) begin
                r_xcnt <= '0;
                r_ycnt <= '0;
            end else if (w_hs_fall) begin
                r_xcnt <= '0;
                if (r_xcnt != '0) r_ycnt <= r_ycnt + CW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.take_photo) r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (w_vs_fall) begin
                        r_state <= S_CAPTURE;
                        r_band  <= '0;
                        r_col   <= '0;
                        r_waddr <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (r_yv && r_ywin) r_acc[r_ybin] <= r_acc[r_ybin] + ACC_W'(r_luma);
                    if (w_vs_rise) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                        for (int i = 0; i < OUT_W; i++) r_acc[i] <= '0;
                    end else if (w_hs_fall && r_xcnt != '0 && w_band_end) begin
                        r_state <= S_FLUSH;
                        r_col   <= '0;
                    end
                end
                S_FLUSH: begin
                    // Pixels arriving here are dropped: the accumulators are busy draining.
                    if (w_hs_rise) r_overrun <= 1'b1;
                    if (w_vs_rise) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                        for (int i = 0; i < OUT_W; i++) r_acc[i] <= '0;
                    end else begin
                        r_we         <= 1'b1;
                        r_addr       <= r_waddr;
                        r_din        <= DOUT_W'(w_wval);
                        r_acc[r_col] <= '0;
                        r_waddr      <= r_waddr + ADDR_W'(1);
                        if (r_col == BW'(OUT_W - 1)) begin
                            r_state <= (r_band == HW'(OUT_H - 1)) ? S_DONE : S_CAPTURE;
                            r_band  <= r_band + HW'(1);
                        end else begin
                            r_col <= r_col + BW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.bram_addr_cam = r_addr;
    assign bus.bram_din_cam  = r_din;
    assign bus.bram_en_cam   = r_we;
    assign bus.bram_we_cam   = r_we;
    assign bus.ready         = (r_state == S_IDLE);
    assign bus.frame_done    = r_done;
    assign bus.frame_err     = r_err;
    assign bus.overrun       = r_overrun;
endmodule
